// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receiver and transmitter.
//   - uart_state_e : receiver frame states.
//   - UART_CLKS_PER_BIT_DEF / UART_DATA_BITS_DEF : default timing and width,
//     shared so both ends of the link agree on bit timing.
`timescale 1ns/1ps
package uart_pkg;

  localparam int unsigned UART_CLKS_PER_BIT_DEF = 16;
  localparam int unsigned UART_DATA_BITS_DEF    = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: free-running bit-period counter for the UART receiver.
// Counts 0..ClksPerBit-1 and wraps; clr_i forces the count back to 0.
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous active-high reset (count to 0)
//   clr_i       in   restart the bit period (count is 0 in the next cycle)
//   half_tick_o out  count == ClksPerBit/2-1 (bit centre after a clear on an edge)
//   full_tick_o out  count == ClksPerBit-1 (one full period elapsed)
`timescale 1ns/1ps
module uart_bit_timer #(
  parameter int unsigned ClksPerBit = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic half_tick_o,
  output logic full_tick_o
);

  localparam int unsigned CntW = $clog2(ClksPerBit);
  localparam logic [CntW-1:0] HalfM1 = CntW'(ClksPerBit / 2 - 1);
  localparam logic [CntW-1:0] FullM1 = CntW'(ClksPerBit - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clr_i || (cnt_q == FullM1)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign half_tick_o = (cnt_q == HalfM1);
  assign full_tick_o = (cnt_q == FullM1);

endmodule

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: self-timed UART receiver (8N1 by default).
// Recovers frames from the asynchronous rxIn line with its own bit timer and
// presents each good byte through a one-deep valid/ack holding register.
// Optional feature: define UART_PARITY_EN for an even-parity bit after the data
// bits and a parityErr output.
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   rxIn       in   serial line, idles high
//   rxAck      in   consumer takes rxData while rxValid=1
//   rxData     out  last accepted byte, changes only on a commit
//   rxValid    out  holding register full
//   rxBusy     out  receiver is inside a frame (not IDLE)
//   frameErr   out  1-cycle pulse: stop bit sampled low
//   parityErr  out  1-cycle pulse: parity mismatch (UART_PARITY_EN only)
//   overrun    out  1-cycle pulse: good frame dropped, holding register full
`timescale 1ns/1ps
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF,
  parameter int unsigned DATA_BITS    = UART_DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxIn,
  input  logic                 rxAck,
  output logic [DATA_BITS-1:0] rxData,
  output logic                 rxValid,
  output logic                 rxBusy,
  output logic                 frameErr,
`ifdef UART_PARITY_EN
  output logic                 parityErr,
`endif
  output logic                 overrun
);

  localparam int unsigned IdxW = $clog2(DATA_BITS + 1);

  // Two-flop synchroniser plus one delayed copy for edge detection.
  logic sync_q, rx_s_q, rx_prev_q;

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IdxW-1:0]      bit_idx_q, bit_idx_d;
  logic                 commit_q, commit_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
`ifdef UART_PARITY_EN
  logic                 par_bit_q, par_bit_d;
  logic                 parity_err_q, parity_err_d;
`endif

  logic timer_clr, half_tick, full_tick;

  uart_bit_timer #(
    .ClksPerBit (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (timer_clr),
    .half_tick_o (half_tick),
    .full_tick_o (full_tick)
  );

  // Frame FSM and shift register.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    timer_clr   = 1'b0;
    commit_d    = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_PARITY_EN
    par_bit_d    = par_bit_q;
    parity_err_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        // A true falling edge is required, so a held-low (break) line after a
        // framing error cannot restart reception until it has gone high.
        if (rx_prev_q && !rx_s_q) begin
          state_d   = START;
          timer_clr = 1'b1;
        end
      end
      START: begin
        if (half_tick) begin
          if (!rx_s_q) begin
            state_d   = DATA;
            timer_clr = 1'b1;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (full_tick) begin
          shift_d              = shift_q >> 1;
          shift_d[DATA_BITS-1] = rx_s_q;
          bit_idx_d            = bit_idx_q + IdxW'(1);
          if (bit_idx_q == IdxW'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
      PARITY: begin
`ifdef UART_PARITY_EN
        if (full_tick) begin
          par_bit_d = rx_s_q;
          state_d   = STOP;
        end
`else
        state_d = IDLE;
`endif
      end
      STOP: begin
        if (full_tick) begin
          state_d = IDLE;
          if (!rx_s_q) begin
            frame_err_d = 1'b1;
`ifdef UART_PARITY_EN
          end else if (^{shift_q, par_bit_q}) begin
            parity_err_d = 1'b1;
`endif
          end else begin
            commit_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Holding register: commit happens the cycle after the stop sample.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (commit_q) begin
      if (valid_q && !rxAck) begin
        overrun_d = 1'b1;
      end else begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end
    end else if (valid_q && rxAck) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q       <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_prev_q    <= 1'b1;
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_idx_q    <= '0;
      commit_q     <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_PARITY_EN
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync_q       <= rxIn;
      rx_s_q       <= sync_q;
      rx_prev_q    <= rx_s_q;
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_idx_q    <= bit_idx_d;
      commit_q     <= commit_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef UART_PARITY_EN
      par_bit_q    <= par_bit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rxData   = data_q;
  assign rxValid  = valid_q;
  assign rxBusy   = (state_q != IDLE);
  assign frameErr = frame_err_q;
  assign overrun  = overrun_q;
`ifdef UART_PARITY_EN
  assign parityErr = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb_uart_rx_sampler: directed self-checking bench for uart_rx_sampler
// (16 clocks per bit, 10 ns clock). Define UART_PARITY_EN to exercise parity.
`timescale 1ns/1ps
module tb_uart_rx_sampler;

  localparam int unsigned Cpb = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxIn;
  logic       rxAck;
  logic [7:0] rxData;
  logic       rxValid;
  logic       rxBusy;
  logic       frameErr;
  logic       overrun;
`ifdef UART_PARITY_EN
  logic       parityErr;
  int         pe_cnt = 0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;

  uart_rx_sampler #(
    .CLKS_PER_BIT (Cpb),
    .DATA_BITS    (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rxIn      (rxIn),
    .rxAck     (rxAck),
    .rxData    (rxData),
    .rxValid   (rxValid),
    .rxBusy    (rxBusy),
    .frameErr  (frameErr),
`ifdef UART_PARITY_EN
    .parityErr (parityErr),
`endif
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Pulse counters: one count per cycle the pulse is high.
  always @(negedge clk) begin
    if (frameErr) fe_cnt <= fe_cnt + 1;
    if (overrun)  ov_cnt <= ov_cnt + 1;
`ifdef UART_PARITY_EN
    if (parityErr) pe_cnt <= pe_cnt + 1;
`endif
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rxIn = b;
    repeat (Cpb) @(negedge clk);
  endtask

  // Frame with correct parity (when enabled) and a chosen stop-bit level.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_PARITY_EN
    send_bit(^d);
`endif
    send_bit(stop);
  endtask

`ifdef UART_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(1'b1);
  endtask
`endif

  task automatic idle(input int n);
    rxIn = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic ack_pulse();
    rxAck = 1'b1;
    @(negedge clk);
    rxAck = 1'b0;
    @(negedge clk);
  endtask

  int fe0, ov0;

  initial begin
    rst   = 1'b1;
    rxIn  = 1'b1;
    rxAck = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("reset_valid", 32'(rxValid), 32'd0);
    check_eq("reset_data", 32'(rxData), 32'h00);
    check_eq("reset_busy", 32'(rxBusy), 32'd0);
    check_eq("reset_ferr", 32'(frameErr), 32'd0);
    check_eq("reset_ovr", 32'(overrun), 32'd0);
    rst = 1'b0;
    idle(4);

    // 1: basic frame
    fe0 = fe_cnt;
    send_frame(8'hA5, 1'b1);
    idle(4);
    check_eq("t1_valid", 32'(rxValid), 32'd1);
    check_eq("t1_data", 32'(rxData), 32'hA5);
    check_eq("t1_no_ferr", 32'(fe_cnt - fe0), 32'd0);
    ack_pulse();
    check_eq("t1_ack_clears", 32'(rxValid), 32'd0);
    ack_pulse();
    check_eq("t1_ack_idle_valid", 32'(rxValid), 32'd0);
    check_eq("t1_ack_idle_data", 32'(rxData), 32'hA5);

    // 2: short glitch rejected, then a good frame
    fe0 = fe_cnt;
    rxIn = 1'b0;
    repeat (5) @(negedge clk);
    idle(30);
    check_eq("t2_glitch_busy", 32'(rxBusy), 32'd0);
    check_eq("t2_glitch_valid", 32'(rxValid), 32'd0);
    check_eq("t2_glitch_ferr", 32'(fe_cnt - fe0), 32'd0);
    send_frame(8'h3C, 1'b1);
    idle(4);
    check_eq("t2_valid", 32'(rxValid), 32'd1);
    check_eq("t2_data", 32'(rxData), 32'h3C);
    ack_pulse();

    // 3: stop bit low, line held in break
    fe0 = fe_cnt;
    send_frame(8'h55, 1'b0);
    rxIn = 1'b0;
    repeat (40) @(negedge clk);
    check_eq("t3_one_ferr", 32'(fe_cnt - fe0), 32'd1);
    check_eq("t3_no_valid", 32'(rxValid), 32'd0);
    idle(20);
    check_eq("t3_ferr_after_break", 32'(fe_cnt - fe0), 32'd1);
    check_eq("t3_busy_after_break", 32'(rxBusy), 32'd0);
    send_frame(8'h0F, 1'b1);
    idle(4);
    check_eq("t3_valid", 32'(rxValid), 32'd1);
    check_eq("t3_data", 32'(rxData), 32'h0F);
    ack_pulse();

    // 4: overrun, then replace with ack in the commit cycle
    ov0 = ov_cnt;
    send_frame(8'h11, 1'b1);
    idle(4);
    check_eq("t4_first_data", 32'(rxData), 32'h11);
    send_frame(8'h22, 1'b1);
    idle(4);
    check_eq("t4_overrun", 32'(ov_cnt - ov0), 32'd1);
    check_eq("t4_data_kept", 32'(rxData), 32'h11);
    check_eq("t4_valid_kept", 32'(rxValid), 32'd1);
    fork
      send_frame(8'h33, 1'b1);
      begin
        int w = 0;
        while (!rxBusy && w < 400) begin @(negedge clk); w++; end
        while (rxBusy && w < 400) begin @(negedge clk); w++; end
        check_eq("t4_commit_window", 32'(w < 400), 32'd1);
        rxAck = 1'b1;
        @(negedge clk);
        rxAck = 1'b0;
      end
    join
    idle(4);
    check_eq("t4_ack_commit_data", 32'(rxData), 32'h33);
    check_eq("t4_ack_commit_valid", 32'(rxValid), 32'd1);
    check_eq("t4_no_extra_overrun", 32'(ov_cnt - ov0), 32'd1);

    // 5: reset in the middle of a frame
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (80) @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("t5_rst_busy", 32'(rxBusy), 32'd0);
        check_eq("t5_rst_valid", 32'(rxValid), 32'd0);
        check_eq("t5_rst_data", 32'(rxData), 32'h00);
      end
    join
    @(negedge clk);
    rst = 1'b0;
    idle(4);
    send_frame(8'h81, 1'b1);
    idle(4);
    check_eq("t5_valid", 32'(rxValid), 32'd1);
    check_eq("t5_data", 32'(rxData), 32'h81);
    ack_pulse();

`ifdef UART_PARITY_EN
    // 6: even parity
    begin
      int pe0;
      pe0 = pe_cnt;
      ov0 = ov_cnt;
      send_frame_par(8'h07, 1'b1);
      idle(4);
      check_eq("t6_good_valid", 32'(rxValid), 32'd1);
      check_eq("t6_good_data", 32'(rxData), 32'h07);
      check_eq("t6_good_no_perr", 32'(pe_cnt - pe0), 32'd0);
      ack_pulse();
      send_frame_par(8'h07, 1'b0);
      idle(4);
      check_eq("t6_bad_perr", 32'(pe_cnt - pe0), 32'd1);
      check_eq("t6_bad_no_valid", 32'(rxValid), 32'd0);
      check_eq("t6_bad_no_overrun", 32'(ov_cnt - ov0), 32'd0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
